// File: rtl/uart_script_checker.sv
// Script-driven UART host agent: replays SEND/EXPECT/WAIT/END against a DUT UART.
// Define PARITY_EN to add an even-parity bit to both directions.
module uart_script_checker #(
    parameter int    CLOCK_FREQ     = 50_000_000,
    parameter int    BAUD_RATE      = 1_000_000,
    parameter int    DATA_BITS      = 8,
    parameter int    SCRIPT_DEPTH   = 256,
    parameter int    RX_FIFO_DEPTH  = 16,
    parameter int    GAP_CYCLES     = 500,
    parameter int    TIMEOUT_CYCLES = 100_000,
    parameter string SCRIPT_HEX     = ""
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        prog_we,
    input  logic [$clog2(SCRIPT_DEPTH)-1:0] prog_addr,
    input  logic [DATA_BITS+1:0]        prog_data,
    input  logic                        serial_in,
    output logic                        serial_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [15:0]                 fail_count,
    output logic                        timeout,
    output logic                        rx_overflow,
    output logic                        mismatch,
    output logic [DATA_BITS-1:0]        last_got,
    output logic [$clog2(SCRIPT_DEPTH)-1:0] entry_idx
);

    localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int AW   = $clog2(SCRIPT_DEPTH);
    localparam int FW   = $clog2(RX_FIFO_DEPTH);
    localparam int EW   = DATA_BITS + 2;
    localparam int CW   = 32;
`ifdef PARITY_EN
    localparam int TXW  = DATA_BITS + 2;
`else
    localparam int TXW  = DATA_BITS + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_GAP, S_EXPECT, S_WAIT, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP
    } rx_state_t;

    // Script memory and registered entry read
    logic [EW-1:0]        script_mem [SCRIPT_DEPTH];
    logic [EW-1:0]        ent_q;
    logic [1:0]           op;
    logic [DATA_BITS-1:0] arg;

    // RX FIFO
    logic [DATA_BITS:0]   fifo_mem [RX_FIFO_DEPTH];
    logic [FW:0]          wr_ptr_q, wr_ptr_d;
    logic [FW:0]          rd_ptr_q, rd_ptr_d;
    logic                 fifo_empty, fifo_full;
    logic                 fifo_push, fifo_pop, fifo_clr;
    logic [DATA_BITS:0]   fifo_head;

    // RX path
    logic                 sync1_q, sync2_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_err_q, rx_err_d;
    logic                 rx_push;
    logic [DATA_BITS:0]   rx_word;

    // Script engine
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [TXW-1:0]       tx_shift_q, tx_shift_d;
    logic [3:0]           tx_bits_q, tx_bits_d;
    logic                 serial_out_q, serial_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [15:0]          fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic                 ovf_q, ovf_d;
    logic                 mismatch_q, mismatch_d;
    logic [DATA_BITS-1:0] last_got_q, last_got_d;
    logic [1:0]           fail_inc;
    logic                 fail_clr;
    logic                 adv;
    logic [16:0]          fail_sum;
    logic [CW-1:0]        wait_len;

    assign op  = ent_q[EW-1:EW-2];
    assign arg = ent_q[DATA_BITS-1:0];

    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            script_mem[prog_addr] <= prog_data;
        end
        ent_q <= script_mem[idx_d];
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FW] != rd_ptr_q[FW]) &&
                        (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[FW-1:0]];
    assign fifo_push  = rx_push && !fifo_clr && (!fifo_full || fifo_pop);
    assign wr_ptr_d   = fifo_clr ? '0 : wr_ptr_q + (FW+1)'(fifo_push);
    assign rd_ptr_d   = fifo_clr ? '0 : rd_ptr_q + (FW+1)'(fifo_pop);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[FW-1:0]] <= rx_word;
        end
    end

    // Receiver: glitch-filtered start, mid-bit sampling, error tag on bad stop/parity
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_err_d   = rx_err_q;
        rx_push    = 1'b0;
        rx_word    = {rx_err_q | ~sync2_q, rx_shift_q};
        unique case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (!sync2_q) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == CW'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_err_d   = 1'b0;
                    rx_state_d = sync2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
                        rx_state_d = R_PAR;
`else
                        rx_state_d = R_STOP;
`endif
                    end
                end
            end
            R_PAR: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_err_d   = sync2_q ^ (^rx_shift_q);
                    rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_push    = 1'b1;
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    assign wait_len = CW'({arg, 8'h00});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        tx_shift_d   = tx_shift_q;
        tx_bits_d    = tx_bits_q;
        serial_out_d = serial_out_q;
        timeout_d    = timeout_q;
        ovf_d        = ovf_q;
        last_got_d   = last_got_q;
        mismatch_d   = 1'b0;
        fifo_pop     = 1'b0;
        fifo_clr     = 1'b0;
        fail_inc     = 2'd0;
        fail_clr     = 1'b0;
        adv          = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    fifo_clr  = 1'b1;
                    fail_clr  = 1'b1;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                    idx_d     = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                cnt_d = '0;
                unique case (op)
                    2'b00: state_d = S_DONE;
                    2'b01: begin
                        serial_out_d = 1'b0;
`ifdef PARITY_EN
                        tx_shift_d   = {1'b1, ^arg, arg};
`else
                        tx_shift_d   = {1'b1, arg};
`endif
                        tx_bits_d    = 4'(TXW);
                        state_d      = S_SEND;
                    end
                    2'b10: state_d = S_EXPECT;
                    default: begin
                        if (arg == '0) adv = 1'b1;
                        else state_d = S_WAIT;
                    end
                endcase
            end
            S_SEND: begin
                cnt_d = cnt_q + 1;
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (tx_bits_q == 4'd0) begin
                        if (GAP_CYCLES == 0) adv = 1'b1;
                        else state_d = S_GAP;
                    end else begin
                        serial_out_d = tx_shift_q[0];
                        tx_shift_d   = tx_shift_q >> 1;
                        tx_bits_d    = tx_bits_q - 4'd1;
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1;
                if (cnt_q == CW'(GAP_CYCLES - 1)) adv = 1'b1;
            end
            S_EXPECT: begin
                cnt_d = cnt_q + 1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    last_got_d = fifo_head[DATA_BITS-1:0];
                    if (fifo_head[DATA_BITS] ||
                        fifo_head[DATA_BITS-1:0] != arg) begin
                        fail_inc   = 2'd1;
                        mismatch_d = 1'b1;
                    end
                    adv = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    fail_inc  = 2'd1;
                    state_d   = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1;
                if (cnt_q == wait_len - 1) adv = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (idx_q == AW'(SCRIPT_DEPTH - 1)) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = S_FETCH;
            end
        end

        // A dropped character counts against the run even with no EXPECT pending
        if (rx_push && !fifo_clr && fifo_full && !fifo_pop) begin
            ovf_d    = 1'b1;
            fail_inc = fail_inc + 2'd1;
        end

        fail_sum = {1'b0, fail_q} + {15'd0, fail_inc};
        if (fail_clr)         fail_d = '0;
        else if (fail_sum[16]) fail_d = 16'hFFFF;
        else                  fail_d = fail_sum[15:0];

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (fail_d == '0) && !timeout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_state_q   <= R_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_err_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            tx_shift_q   <= '0;
            tx_bits_q    <= '0;
            serial_out_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= '0;
            timeout_q    <= 1'b0;
            ovf_q        <= 1'b0;
            mismatch_q   <= 1'b0;
            last_got_q   <= '0;
        end else begin
            sync1_q      <= serial_in;
            sync2_q      <= sync1_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_err_q     <= rx_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_bits_q    <= tx_bits_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            ovf_q        <= ovf_d;
            mismatch_q   <= mismatch_d;
            last_got_q   <= last_got_d;
        end
    end

    assign serial_out  = serial_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_count  = fail_q;
    assign timeout     = timeout_q;
    assign rx_overflow = ovf_q;
    assign mismatch    = mismatch_q;
    assign last_got    = last_got_q;
    assign entry_idx   = idx_q;

endmodule

// File: tb/tb_uart_script_checker.sv
// Directed bench for uart_script_checker: frame timing, loopback, timeout,
// overflow, glitch/framing errors and mid-frame reset.
module tb_uart_script_checker;

    localparam int DIV = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [9:0]  prog_data = '0;
    logic        loopback = 1'b0;
    logic        drv_rx = 1'b1;
    logic        dut_rx;
    logic        serial_out, busy, done, pass, timeout, rx_overflow, mismatch;
    logic [15:0] fail_count;
    logic [7:0]  last_got;
    logic [4:0]  entry_idx;

    int n_checks = 0;
    int n_fail = 0;
    int mm_cnt = 0;
    int mm_base;

    assign dut_rx = loopback ? serial_out : drv_rx;

    uart_script_checker #(
        .CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
        .SCRIPT_DEPTH(32), .RX_FIFO_DEPTH(16), .GAP_CYCLES(20),
        .TIMEOUT_CYCLES(2000), .SCRIPT_HEX("")
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .serial_in(dut_rx),
        .serial_out(serial_out), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .timeout(timeout), .rx_overflow(rx_overflow),
        .mismatch(mismatch), .last_got(last_got), .entry_idx(entry_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mismatch === 1'b1) mm_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int a, input logic [1:0] op,
                        input logic [7:0] arg);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = 5'(a);
        prog_data = {op, arg};
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    // Called at the negedge right after the start edge
    task automatic sample_frame(input logic [7:0] d, input string tag);
        check({tag, "_pre"}, serial_out, 1);
        @(negedge clk);
        check({tag, "_edge"}, serial_out, 0);
        repeat (25) @(negedge clk);
        check({tag, "_start"}, serial_out, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            check($sformatf("%s_b%0d", tag, i), serial_out, d[i]);
        end
`ifdef PARITY_EN
        repeat (DIV) @(negedge clk);
        check({tag, "_par"}, serial_out, ^d);
`endif
        repeat (DIV) @(negedge clk);
        check({tag, "_stop"}, serial_out, 1);
    endtask

    task automatic send_char(input logic [7:0] d, input logic stop_bit);
        drv_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv_rx = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef PARITY_EN
        drv_rx = ^d;
        repeat (DIV) @(negedge clk);
`endif
        drv_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        drv_rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_serial_out", serial_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail_count, 0);
        check("rst_timeout", timeout, 0);
        check("rst_ovf", rx_overflow, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_last_got", last_got, 0);
        check("rst_idx", entry_idx, 0);

        // SEND 0x61 then END
        prog(0, 2'b01, 8'h61);
        prog(1, 2'b00, 8'h00);
        pulse_start();
        check("t1_busy", busy, 1);
        sample_frame(8'h61, "t1");
        wait_done(200, "t1_done");
        check("t1_pass", pass, 1);
        check("t1_busy_end", busy, 0);
        check("t1_fail", fail_count, 0);

        // Loopback: one good EXPECT, one bad
        loopback = 1'b1;
        prog(0, 2'b01, 8'h55);
        prog(1, 2'b10, 8'h55);
        prog(2, 2'b01, 8'hA3);
        prog(3, 2'b10, 8'h00);
        prog(4, 2'b00, 8'h00);
        mm_base = mm_cnt;
        pulse_start();
        wait_done(5000, "t2_done");
        check("t2_fail", fail_count, 1);
        check("t2_mm_pulses", mm_cnt - mm_base, 1);
        check("t2_last_got", last_got, 8'hA3);
        check("t2_pass", pass, 0);
        check("t2_timeout", timeout, 0);
        loopback = 1'b0;

        // EXPECT with idle line times out
        prog(0, 2'b10, 8'h31);
        prog(1, 2'b00, 8'h00);
        pulse_start();
        repeat (1990) @(negedge clk);
        check("t3_not_yet", done, 0);
        wait_done(100, "t3_done");
        check("t3_timeout", timeout, 1);
        check("t3_fail", fail_count, 1);
        check("t3_pass", pass, 0);
        check("t3_last_got", last_got, 8'hA3);

        // 17 characters into a 16-deep FIFO, then drain 16
        prog(0, 2'b11, 8'd40);
        for (int i = 0; i < 16; i++) prog(i + 1, 2'b10, 8'(i * 13 + 5));
        prog(17, 2'b00, 8'h00);
        mm_base = mm_cnt;
        pulse_start();
        for (int i = 0; i < 17; i++) send_char(8'(i * 13 + 5), 1'b1);
        check("t4_ovf", rx_overflow, 1);
        check("t4_fail_mid", fail_count, 1);
        check("t4_still_waiting", entry_idx, 0);
        wait_done(5000, "t4_done");
        check("t4_fail", fail_count, 1);
        check("t4_no_mm", mm_cnt - mm_base, 0);
        check("t4_last_got", last_got, 8'hC8);
        check("t4_pass", pass, 0);

        // Glitch rejection, then framing error
        prog(0, 2'b11, 8'd2);
        prog(1, 2'b10, 8'h5A);
        prog(2, 2'b00, 8'h00);
        mm_base = mm_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        drv_rx = 1'b0;
        repeat (20) @(negedge clk);
        drv_rx = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_glitch_ovf", rx_overflow, 0);
        check("t5_glitch_idx", entry_idx, 0);
        send_char(8'h5A, 1'b0);
        wait_done(3000, "t5_done");
        check("t5_mm", mm_cnt - mm_base, 1);
        check("t5_fail", fail_count, 1);
        check("t5_last_got", last_got, 8'h5A);
        check("t5_timeout", timeout, 0);

        // Reset during data bit 4, then replay
        prog(0, 2'b01, 8'hC5);
        prog(1, 2'b00, 8'h00);
        pulse_start();
        @(negedge clk);
        repeat (275) @(negedge clk);
        check("t6_bit4", serial_out, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_so", serial_out, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fail", fail_count, 0);
        check("t6_rst_last", last_got, 0);
        check("t6_rst_idx", entry_idx, 0);
        pulse_start();
        sample_frame(8'hC5, "t6");
        wait_done(200, "t6_done");
        check("t6_pass", pass, 1);

`ifdef PARITY_EN
        loopback = 1'b1;
        prog(0, 2'b01, 8'h07);
        prog(1, 2'b10, 8'h07);
        prog(2, 2'b00, 8'h00);
        pulse_start();
        sample_frame(8'h07, "t7");
        wait_done(500, "t7_done");
        check("t7_pass", pass, 1);
        check("t7_last_got", last_got, 8'h07);
        loopback = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
